tlb_refill_ctrl: RTL and testbench
==================================

TLB_REFILL_CTRL -- requirements
Module: tlb_refill_ctrl

Interface
REQ-001 SHALL have parameter ENTRIES, default 4, number of cached translations (power of two, 2..8).
REQ-002 SHALL have parameter VA_W, default 6, virtual address width.
REQ-003 SHALL have parameter PA_W, default 16, translated word width.
REQ-004 SHALL have port Clock  input  1  sole clock, rising edge; one clock, all state on it.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  requester presents a lookup.
REQ-007 SHALL have port req_vaddr  input  VA_W  virtual address to translate.
REQ-008 SHALL have port req_ready  output  1  controller accepts a request this cycle.
REQ-009 SHALL have port resp_valid  output  1  response held until consumed.
REQ-010 SHALL have port resp_ready  input  1  requester consumes the response.
REQ-011 SHALL have port resp_data  output  PA_W  translated word.
REQ-012 SHALL have port resp_fault  output  1  walk reported no translation.
REQ-013 SHALL have port walk_req  output  1  page-table walk request, level-held.
REQ-014 SHALL have port walk_addr  output  VA_W  address being walked.
REQ-015 SHALL have port walk_ack  input  1  walk_data valid this cycle.
REQ-016 SHALL have port walk_fault  input  1  walk failed this cycle.
REQ-017 SHALL have port walk_data  input  PA_W  walked translation.
REQ-018 SHALL have port flush  input  1  invalidate all entries.

Function
REQ-019 SHALL implement FSM IDLE, LOOKUP, WALK, FILL, RESP.
REQ-020 SHALL assert req_ready only in IDLE; on req_valid&req_ready it captures req_vaddr and enters LOOKUP.
REQ-021 SHALL, in LOOKUP, compare the captured address against all valid tags in parallel. Hit -> RESP with the entry data. Miss -> WALK.
REQ-022 SHALL deliver a hit with resp_valid asserted two cycles after the accepting edge.
REQ-023 SHALL, in WALK, hold walk_req=1 and walk_addr=the captured address until walk_ack or walk_fault.
REQ-024 SHALL, on walk_ack, capture walk_data and go to FILL. walk_fault -> RESP with resp_fault=1 and resp_data=0, no fill. Both asserted together -> fault wins.
REQ-025 SHALL, in FILL, write tag/data/valid to the victim in one cycle, then go to RESP with the walked data.
REQ-026 SHALL select the victim as the lowest-index invalid entry; if all entries are valid, the round-robin pointer, which increments modulo ENTRIES only on a valid-entry replacement.
REQ-027 SHALL hold resp_valid, resp_data and resp_fault stable in RESP until resp_ready; then return to IDLE, with req_ready high the following cycle.
REQ-028 SHALL clear all valid bits on the edge flush is sampled high, in any state. Flush in the same cycle as FILL -> the entry stays invalid, but the response is still delivered. The round-robin pointer is unaffected by flush.
REQ-029 SHALL never hold two valid entries with the same tag.

Reset
REQ-030 SHALL, on Reset, enter IDLE immediately, aborting any walk. All valid bits=0, pointer=0, req_ready=1 after release, resp_valid=0, resp_data=0, resp_fault=0, walk_req=0, walk_addr=0.

Configuration
REQ-031 SHALL, with macro TLB_REFILL_STATS_EN defined, add outputs hit_cnt[15:0] and miss_cnt[15:0]. They increment on the LOOKUP hit and miss decision respectively, saturate at 16'hFFFF, reset to 0, and are unaffected by flush.
REQ-032 SHALL, without TLB_REFILL_STATS_EN, omit those ports and counters entirely.

Structure
REQ-033 SHALL take FSM state encoding and the VA_W/PA_W defaults from shared package tlb_pkg.
REQ-034 SHALL place the tag/data/valid array with parallel match and victim select in sub-module tlb_entry_array. The FSM stays in tlb_refill_ctrl.

Verification
REQ-035 SHALL check cold miss: request vaddr 6'h05; walk_ack after 3 cycles with 16'h0841 -> walk_addr=6'h05, then resp_data=16'h0841, resp_fault=0.
REQ-036 SHALL check hit: repeat vaddr 6'h05 -> no walk_req, resp_valid two cycles after acceptance, data 16'h0841.
REQ-037 SHALL check replacement: fill vaddrs 0,1,2,3, then request 4 -> entry 0 replaced. Request 0 again -> walk_req asserted.
REQ-038 SHALL check fault: walk_fault and walk_ack together on vaddr 6'h3F -> resp_fault=1, resp_data=0, and a later request to 6'h3F walks again.
REQ-039 SHALL check backpressure and flush: hold resp_ready=0 for 5 cycles -> response stable, req_ready=0. Then flush during FILL -> next request to the same vaddr misses.
REQ-040 SHALL check reset mid-walk: assert Reset while walk_req=1 -> walk_req drops asynchronously and all entries are invalid. With TLB_REFILL_STATS_EN, both counters read 0.

Source files
------------

// File: rtl/tlb_pkg.sv
// tlb_pkg: shared definitions for the TLB refill controller.
//   tlb_state_e - controller FSM encoding
//   VA_W_DEF    - default virtual address width
//   PA_W_DEF    - default translated word width
package tlb_pkg;

  localparam int VA_W_DEF = 6;
  localparam int PA_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WALK,
    S_FILL,
    S_RESP
  } tlb_state_e;

endpackage

// File: rtl/tlb_entry_array.sv
// tlb_entry_array: tag/data/valid storage with parallel match and victim select.
//   clk, rst        - clock, async active-high reset
//   flush           - clear all valid bits (wins over a same-cycle fill)
//   lookup_tag      - address compared against every valid tag
//   hit, hit_data   - match result and data of the matching entry
//   fill_en         - write fill_tag/fill_data into the victim entry
//   fill_tag/data   - translation being installed
module tlb_entry_array
  import tlb_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = VA_W_DEF,
  parameter int DATA_W  = PA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [DATA_W-1:0] fill_data
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0]             valid;
  logic [ENTRIES-1:0][TAG_W-1:0]  tags;
  logic [ENTRIES-1:0][DATA_W-1:0] data;
  logic [ENTRIES-1:0]             match;
  logic [IDX_W-1:0]               rr_ptr;
  logic [IDX_W-1:0]               victim;
  logic                           all_valid;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_match
    assign match[i] = valid[i] && (tags[i] == lookup_tag);
  end

  // Tags are unique, so at most one match bit is set and OR-ing is a mux.
  always_comb begin
    hit      = |match;
    hit_data = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (match[i]) hit_data = hit_data | data[i];
  end

  // Descending scan leaves the lowest-index invalid entry selected.
  assign all_valid = &valid;
  always_comb begin
    victim = rr_ptr;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!valid[i]) victim = IDX_W'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= '0;
      rr_ptr <= '0;
    end else begin
      if (flush)        valid         <= '0;
      else if (fill_en) valid[victim] <= 1'b1;
      // Pointer only moves when a live entry is evicted; flush leaves it alone.
      if (fill_en && all_valid) rr_ptr <= rr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[victim] <= fill_tag;
      data[victim] <= fill_data;
    end
  end

endmodule

// File: rtl/tlb_refill_ctrl.sv
// tlb_refill_ctrl: single-requester TLB with page-table-walk refill.
//   Clock, Reset                         - clock, async active-high reset
//   req_valid/req_vaddr/req_ready        - lookup request handshake
//   resp_valid/resp_ready/resp_data/resp_fault - held response handshake
//   walk_req/walk_addr                   - level-held walk request
//   walk_ack/walk_fault/walk_data        - walk completion
//   flush                                - invalidate all entries
//   hit_cnt/miss_cnt                     - saturating lookup statistics, present
//                                          only with TLB_REFILL_STATS_EN defined
module tlb_refill_ctrl
  import tlb_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int VA_W    = VA_W_DEF,
  parameter int PA_W    = PA_W_DEF
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            req_valid,
  input  logic [VA_W-1:0] req_vaddr,
  output logic            req_ready,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [PA_W-1:0] resp_data,
  output logic            resp_fault,
  output logic            walk_req,
  output logic [VA_W-1:0] walk_addr,
  input  logic            walk_ack,
  input  logic            walk_fault,
  input  logic [PA_W-1:0] walk_data,
`ifdef TLB_REFILL_STATS_EN
  output logic [15:0]     hit_cnt,
  output logic [15:0]     miss_cnt,
`endif
  input  logic            flush
);

  tlb_state_e      state, state_nxt;
  logic [VA_W-1:0] addr_q;
  logic            hit;
  logic [PA_W-1:0] hit_data;

  tlb_entry_array #(
    .ENTRIES (ENTRIES),
    .TAG_W   (VA_W),
    .DATA_W  (PA_W)
  ) u_array (
    .clk        (Clock),
    .rst        (Reset),
    .flush      (flush),
    .lookup_tag (addr_q),
    .hit        (hit),
    .hit_data   (hit_data),
    .fill_en    (state == S_FILL),
    .fill_tag   (addr_q),
    .fill_data  (resp_data)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req_valid) state_nxt = S_LOOKUP;
      S_LOOKUP: state_nxt = hit ? S_RESP : S_WALK;
      S_WALK: begin
        if (walk_fault)    state_nxt = S_RESP;
        else if (walk_ack) state_nxt = S_FILL;
      end
      S_FILL:   state_nxt = S_RESP;
      S_RESP:   if (resp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign walk_req   = (state == S_WALK);
  assign walk_addr  = walk_req ? addr_q : '0;

  // resp_data doubles as the walked-data holding register through FILL.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      addr_q     <= '0;
      resp_data  <= '0;
      resp_fault <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) addr_q <= req_vaddr;
        S_LOOKUP: if (hit) begin
          resp_data  <= hit_data;
          resp_fault <= 1'b0;
        end
        S_WALK: begin
          if (walk_fault) begin
            resp_data  <= '0;
            resp_fault <= 1'b1;
          end else if (walk_ack) begin
            resp_data  <= walk_data;
            resp_fault <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TLB_REFILL_STATS_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == S_LOOKUP) begin
      if (hit && hit_cnt != 16'hFFFF)   hit_cnt  <= hit_cnt + 16'd1;
      if (!hit && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
module tb_tlb_refill_ctrl;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        req_valid, req_ready;
  logic [5:0]  req_vaddr;
  logic        resp_valid, resp_ready, resp_fault;
  logic [15:0] resp_data;
  logic        walk_req, walk_ack, walk_fault;
  logic [5:0]  walk_addr;
  logic [15:0] walk_data;
  logic        flush;
`ifdef TLB_REFILL_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 Clock = ~Clock;

  tlb_refill_ctrl #(.ENTRIES(4), .VA_W(6), .PA_W(16)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_vaddr  (req_vaddr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_fault (resp_fault),
    .walk_req   (walk_req),
    .walk_addr  (walk_addr),
    .walk_ack   (walk_ack),
    .walk_fault (walk_fault),
    .walk_data  (walk_data),
`ifdef TLB_REFILL_STATS_EN
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
`endif
    .flush      (flush)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // One full request/response transaction. For misses the walk is answered
  // on the third WALK cycle; flush_fill raises flush during the FILL cycle;
  // hold keeps resp_ready low for that many cycles before consuming.
  task automatic xact(input logic [5:0] va, input bit exp_hit, input bit fault,
                      input logic [15:0] wdata, input logic [15:0] exp_data,
                      input bit exp_fault, input bit flush_fill, input int hold);
    chk("idle_req_ready", req_ready, 1);
    req_vaddr = va;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("lookup_resp_valid", resp_valid, 0);
    chk("lookup_req_ready", req_ready, 0);
    step();
    if (exp_hit) begin
      chk("hit_no_walk", walk_req, 0);
    end else begin
      chk("miss_walk_req", walk_req, 1);
      chk("walk_addr", walk_addr, va);
      chk("walk_resp_valid", resp_valid, 0);
      step();
      step();
      chk("walk_held", walk_req, 1);
      walk_ack   = 1'b1;
      walk_fault = fault;
      walk_data  = wdata;
      step();
      walk_ack   = 1'b0;
      walk_fault = 1'b0;
      if (!fault) begin
        chk("fill_resp_valid", resp_valid, 0);
        flush = flush_fill;
        step();
        flush = 1'b0;
      end
    end
    chk("resp_valid", resp_valid, 1);
    chk("resp_data", resp_data, exp_data);
    chk("resp_fault", resp_fault, exp_fault);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_resp_data", resp_data, exp_data);
      chk("bp_req_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("done_resp_valid", resp_valid, 0);
    chk("done_req_ready", req_ready, 1);
  endtask

  initial begin
    Reset = 1'b1;
    req_valid = 0; req_vaddr = '0; resp_ready = 0;
    walk_ack = 0; walk_fault = 0; walk_data = '0; flush = 0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_fault", resp_fault, 0);
    chk("rst_walk_req", walk_req, 0);
    chk("rst_walk_addr", walk_addr, 0);
`ifdef TLB_REFILL_STATS_EN
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
`endif
    step();

    // cold miss then hit
    xact(6'h05, 0, 0, 16'h0841, 16'h0841, 0, 0, 0);
    xact(6'h05, 1, 0, 16'h0000, 16'h0841, 0, 0, 0);

    // replacement: empty the array, fill 0..3, then 4 evicts entry 0
    flush = 1'b1; step(); flush = 1'b0;
    for (int v = 0; v < 4; v++)
      xact(6'(v), 0, 0, 16'hA000 + 16'(v), 16'hA000 + 16'(v), 0, 0, 0);
    xact(6'h04, 0, 0, 16'hA004, 16'hA004, 0, 0, 0);
    xact(6'h01, 1, 0, 16'h0000, 16'hA001, 0, 0, 0);
    xact(6'h02, 1, 0, 16'h0000, 16'hA002, 0, 0, 0);
    xact(6'h03, 1, 0, 16'h0000, 16'hA003, 0, 0, 0);
    xact(6'h04, 1, 0, 16'h0000, 16'hA004, 0, 0, 0);
    xact(6'h00, 0, 0, 16'hA000, 16'hA000, 0, 0, 0);  // evicts vaddr 1, ptr->2
    xact(6'h01, 0, 0, 16'hA001, 16'hA001, 0, 0, 0);  // evicts vaddr 2, ptr->3

    // fault (ack+fault together) is not cached
    xact(6'h3F, 0, 1, 16'hDEAD, 16'h0000, 1, 0, 0);
    xact(6'h3F, 0, 0, 16'h1234, 16'h1234, 0, 0, 0);  // evicts vaddr 3

    // backpressure on a hit
    xact(6'h3F, 1, 0, 16'h0000, 16'h1234, 0, 0, 5);

    // flush during FILL: response still delivered, entry not kept
    xact(6'h2A, 0, 0, 16'h2A2A, 16'h2A2A, 0, 1, 0);
    xact(6'h2A, 0, 0, 16'h5555, 16'h5555, 0, 0, 0);
    xact(6'h2A, 1, 0, 16'h0000, 16'h5555, 0, 0, 0);

    // reset mid-walk
    req_vaddr = 6'h11;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("pre_rst_walk_req", walk_req, 1);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_rst_walk_req", walk_req, 0);
    chk("async_rst_walk_addr", walk_addr, 0);
    chk("async_rst_req_ready", req_ready, 1);
`ifdef TLB_REFILL_STATS_EN
    chk("async_rst_hit_cnt", hit_cnt, 0);
    chk("async_rst_miss_cnt", miss_cnt, 0);
`endif
    @(negedge Clock);
    Reset = 1'b0;
    step();
    xact(6'h2A, 0, 0, 16'h7777, 16'h7777, 0, 0, 0);
    xact(6'h05, 0, 0, 16'h0842, 16'h0842, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
